// File: rtl/medidor_desempenho_pkg.sv
// Shared constants, FSM state type and lane-mask helper for the program-memory loader.
package medidor_desempenho_pkg;

    localparam int ADDR_W = 13;
    localparam int DEPTH  = 8192;
    localparam int CNT_W  = 16;

    typedef enum logic [2:0] {
        IDLE,
        FILL,
        WRITE,
        RD_ISSUE,
        RD_CAPTURE,
        FINISH
    } state_t;

    // Expands a 4-bit byte-enable into a 32-bit mask, one byte of ones per enabled lane.
    function automatic logic [31:0] lane_mask(input logic [3:0] be);
        logic [31:0] mask;
        mask = '0;
        for (int i = 0; i < 4; i++) begin
            mask[i*8 +: 8] = {8{be[i]}};
        end
        return mask;
    endfunction

endpackage

// File: rtl/medidor_desempenho_byte_packer.sv
// Packs accepted bytes little-endian into a 32-bit word and tracks which lanes hold data.
module medidor_desempenho_byte_packer (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        accept,
    input  logic [7:0]  data_byte,
    input  logic        flush_clear,
    output logic [31:0] word,
    output logic [3:0]  be,
    output logic        full
);

    logic [1:0] lane;

    // Load the next lane on each accepted byte; a flush empties the word for the next one.
    always_ff @(posedge clk) begin
        if (!reset_n || flush_clear) begin
            word <= '0;
            be   <= '0;
            lane <= '0;
        end else if (accept) begin
            word[{lane, 3'b000} +: 8] <= data_byte;
            be[lane]                  <= 1'b1;
            lane                      <= lane + 2'd1;
        end
    end

    assign full = (lane == 2'd3);

endmodule

// File: rtl/medidor_desempenho_mem_loader.sv
// Streams bytes into the program memory as packed words, then reads the region back and
// compares additive checksums of what was written against what was read.
module medidor_desempenho_mem_loader
    import medidor_desempenho_pkg::*;
(
    input  logic              clk,
    input  logic              reset_n,
    input  logic              start,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic [CNT_W-1:0]  byte_count,
    input  logic [7:0]        s_data,
    input  logic              s_valid,
    output logic              s_ready,
    output logic [ADDR_W-1:0] m_address,
    output logic [3:0]        m_byteenable,
    output logic              m_chipselect,
    output logic              m_write,
    output logic [31:0]       m_writedata,
    output logic              m_clken,
    input  logic [31:0]       m_readdata,
    output logic              busy,
    output logic              done,
    output logic              error,
    output logic              mismatch,
    output logic [31:0]       checksum
);

    state_t            state;
    state_t            state_next;
    logic [ADDR_W-1:0] base_q;
    logic [CNT_W-1:0]  remaining;
    logic [CNT_W-1:0]  rd_left;
    logic [31:0]       wsum;
    logic [31:0]       rsum;
    logic [31:0]       rsum_next;
    logic [31:0]       rd_mask;
    logic [3:0]        last_be;
    logic [CNT_W:0]    nwords;
    logic [CNT_W:0]    range_end;
    logic              range_err;
    logic              accept;
    logic              flush_clear;
    logic              full;
    logic [31:0]       word;
    logic [3:0]        be;

    assign nwords      = ({1'b0, byte_count} + (CNT_W+1)'(3)) >> 2;
    assign range_end   = (CNT_W+1)'(base_addr) + nwords;
    assign range_err   = range_end > (CNT_W+1)'(DEPTH);
    assign accept      = s_valid & s_ready;
    assign flush_clear = (state == WRITE) || ((state == IDLE) && start);
    assign rd_mask     = (rd_left == CNT_W'(1)) ? lane_mask(last_be) : '1;
    assign rsum_next   = rsum + (m_readdata & rd_mask);

    assign m_clken      = reset_n;
    assign m_writedata  = word;
    assign m_byteenable = be;

    medidor_desempenho_byte_packer u_packer (
        .clk         (clk),
        .reset_n     (reset_n),
        .accept      (accept),
        .data_byte   (s_data),
        .flush_clear (flush_clear),
        .word        (word),
        .be          (be),
        .full        (full)
    );

    // State register.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state decode; a zero-length or out-of-range session skips straight to FINISH.
    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (start) begin
                    if ((byte_count == '0) || range_err) begin
                        state_next = FINISH;
                    end else begin
                        state_next = FILL;
                    end
                end
            end
            FILL: begin
                if (accept && (full || (remaining == CNT_W'(1)))) begin
                    state_next = WRITE;
                end
            end
            WRITE: begin
                state_next = (remaining == '0) ? RD_ISSUE : FILL;
            end
            RD_ISSUE: begin
                state_next = RD_CAPTURE;
            end
            RD_CAPTURE: begin
                state_next = (rd_left == CNT_W'(1)) ? FINISH : RD_ISSUE;
            end
            FINISH: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Handshake and strobe outputs are registered from the state being entered.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            s_ready      <= 1'b0;
            m_chipselect <= 1'b0;
            m_write      <= 1'b0;
            busy         <= 1'b0;
            done         <= 1'b0;
        end else begin
            s_ready      <= (state_next == FILL);
            m_chipselect <= (state_next == WRITE) || (state_next == RD_ISSUE);
            m_write      <= (state_next == WRITE);
            busy         <= (state_next != IDLE);
            done         <= (state_next == FINISH);
        end
    end

    // Counters, shared write/read address pointer, checksums and sticky status flags.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            base_q    <= '0;
            remaining <= '0;
            rd_left   <= '0;
            wsum      <= '0;
            rsum      <= '0;
            last_be   <= '0;
            m_address <= '0;
            error     <= 1'b0;
            mismatch  <= 1'b0;
            checksum  <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        base_q    <= base_addr;
                        remaining <= byte_count;
                        rd_left   <= nwords[CNT_W-1:0];
                        m_address <= base_addr;
                        wsum      <= '0;
                        rsum      <= '0;
                        mismatch  <= 1'b0;
                        error     <= range_err;
                        if ((byte_count == '0) || range_err) begin
                            checksum <= '0;
                        end
                    end
                end
                FILL: begin
                    if (accept && (remaining != '0)) begin
                        remaining <= remaining - CNT_W'(1);
                    end
                end
                WRITE: begin
                    wsum    <= wsum + word;
                    last_be <= be;
                    if (remaining == '0) begin
                        m_address <= base_q;
                    end else begin
                        m_address <= m_address + ADDR_W'(1);
                    end
                end
                RD_CAPTURE: begin
                    rsum <= rsum_next;
                    if (rd_left != '0) begin
                        rd_left <= rd_left - CNT_W'(1);
                    end
                    if (rd_left == CNT_W'(1)) begin
                        mismatch <= (rsum_next != wsum);
                        checksum <= wsum;
                    end else begin
                        m_address <= m_address + ADDR_W'(1);
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_medidor_desempenho_mem_loader.sv
// Directed self-checking bench for the program-memory loader with a byte-lane memory model.
module tb_medidor_desempenho_mem_loader;
    import medidor_desempenho_pkg::*;

    logic              clk = 1'b0;
    logic              reset_n;
    logic              start;
    logic [ADDR_W-1:0] base_addr;
    logic [CNT_W-1:0]  byte_count;
    logic [7:0]        s_data;
    logic              s_valid;
    logic              s_ready;
    logic [ADDR_W-1:0] m_address;
    logic [3:0]        m_byteenable;
    logic              m_chipselect;
    logic              m_write;
    logic [31:0]       m_writedata;
    logic              m_clken;
    logic [31:0]       m_readdata;
    logic              busy;
    logic              done;
    logic              error;
    logic              mismatch;
    logic [31:0]       checksum;

    int checks;
    int failures;

    logic [31:0]       mem [0:DEPTH-1];
    logic              mem_fill;
    logic              flip_en;
    logic [ADDR_W-1:0] flip_addr;

    int                wr_count;
    int                cs_count;
    int                rd_count;
    int                ready_viol;
    logic [ADDR_W-1:0] wr_addr_log [0:63];
    logic [31:0]       wr_data_log [0:63];
    logic [3:0]        wr_be_log   [0:63];

    logic [7:0]        stream_q [$];

    always #5 clk = ~clk;

    medidor_desempenho_mem_loader dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .start        (start),
        .base_addr    (base_addr),
        .byte_count   (byte_count),
        .s_data       (s_data),
        .s_valid      (s_valid),
        .s_ready      (s_ready),
        .m_address    (m_address),
        .m_byteenable (m_byteenable),
        .m_chipselect (m_chipselect),
        .m_write      (m_write),
        .m_writedata  (m_writedata),
        .m_clken      (m_clken),
        .m_readdata   (m_readdata),
        .busy         (busy),
        .done         (done),
        .error        (error),
        .mismatch     (mismatch),
        .checksum     (checksum)
    );

    // Memory model: byte-lane writes, one-cycle read latency, optional bit-0 corruption on readback.
    always @(posedge clk) begin
        if (mem_fill) begin
            for (int i = 0; i < DEPTH; i++) mem[i] <= 32'hFFFF_FFFF;
        end else if (m_chipselect && m_write) begin
            for (int k = 0; k < 4; k++) begin
                if (m_byteenable[k]) mem[m_address][k*8 +: 8] <= m_writedata[k*8 +: 8];
            end
        end
        if (m_chipselect && !m_write) begin
            m_readdata <= mem[m_address] ^ ((flip_en && (m_address == flip_addr)) ? 32'h1 : 32'h0);
        end
    end

    // Strobe counters and write log.
    always @(posedge clk) begin
        if (m_chipselect) cs_count <= cs_count + 1;
        if (m_chipselect && m_write) begin
            if (wr_count < 64) begin
                wr_addr_log[wr_count] <= m_address;
                wr_data_log[wr_count] <= m_writedata;
                wr_be_log[wr_count]   <= m_byteenable;
            end
            wr_count <= wr_count + 1;
        end
        if (m_chipselect && !m_write) rd_count <= rd_count + 1;
    end

    // Flags s_ready being high while a memory strobe or completion pulse is out.
    always @(negedge clk) begin
        if (s_ready && (m_chipselect || m_write || done)) ready_viol <= ready_viol + 1;
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog timeout checks=%0d failures=%0d", checks, failures);
        $fatal(1, "[TB] watchdog");
    end

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected) else begin
            failures++;
            $error("[TB] FAIL %s observed=0x%08h expected=0x%08h", tag, observed, expected);
        end
    endtask

    task automatic applyStimulus(input logic [ADDR_W-1:0] base, input logic [CNT_W-1:0] count);
        base_addr  = base;
        byte_count = count;
        start      = 1'b1;
        @(negedge clk);
        start      = 1'b0;
    endtask

    task automatic streamBytes(input bit gaps);
        int t;
        for (int i = 0; i < stream_q.size(); i++) begin
            if (gaps) begin
                s_valid = 1'b0;
                repeat ($urandom_range(0, 3)) @(negedge clk);
            end
            s_valid = 1'b1;
            s_data  = stream_q[i];
            t = 0;
            while (s_ready !== 1'b1 && t < 200) begin
                @(negedge clk);
                t++;
            end
            if (s_ready !== 1'b1) begin
                checkOutput("stream_ready", 32'(s_ready), 32'h1);
                s_valid = 1'b0;
                return;
            end
            @(negedge clk);
        end
        s_valid = 1'b0;
    endtask

    task automatic waitDone(input string tag);
        int t;
        t = 0;
        while (done !== 1'b1 && t < 500) begin
            @(negedge clk);
            t++;
        end
        checkOutput({tag, "_done"}, 32'(done), 32'h1);
    endtask

    initial begin
        int wb;
        int cb;
        int rb;

        reset_n    = 1'b0;
        start      = 1'b0;
        base_addr  = '0;
        byte_count = '0;
        s_data     = '0;
        s_valid    = 1'b0;
        mem_fill   = 1'b1;
        flip_en    = 1'b0;
        flip_addr  = '0;
        repeat (2) @(negedge clk);
        mem_fill = 1'b0;

        checkOutput("rst_busy", 32'(busy), 32'h0);
        checkOutput("rst_done", 32'(done), 32'h0);
        checkOutput("rst_error", 32'(error), 32'h0);
        checkOutput("rst_mismatch", 32'(mismatch), 32'h0);
        checkOutput("rst_checksum", checksum, 32'h0);
        checkOutput("rst_s_ready", 32'(s_ready), 32'h0);
        checkOutput("rst_cs", 32'(m_chipselect), 32'h0);
        checkOutput("rst_write", 32'(m_write), 32'h0);
        checkOutput("rst_addr", 32'(m_address), 32'h0);
        checkOutput("rst_clken", 32'(m_clken), 32'h0);
        reset_n = 1'b1;
        @(negedge clk);
        checkOutput("run_clken", 32'(m_clken), 32'h1);
        checkOutput("idle_busy", 32'(busy), 32'h0);

        $display("[TB] basic load with idle s_valid and a start while busy");
        s_valid = 1'b1;
        s_data  = 8'hFF;
        repeat (2) @(negedge clk);
        s_valid = 1'b0;
        checkOutput("idle_s_ready", 32'(s_ready), 32'h0);
        wb = wr_count; rb = rd_count;
        applyStimulus(13'h0000, 16'd8);
        checkOutput("basic_busy", 32'(busy), 32'h1);
        applyStimulus(13'h0100, 16'd4);
        stream_q = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h07, 8'h08};
        streamBytes(1'b0);
        checkOutput("basic_latency_write", 32'(m_write), 32'h1);
        checkOutput("basic_latency_data", m_writedata, 32'h0807_0605);
        checkOutput("basic_latency_addr", 32'(m_address), 32'h1);
        waitDone("basic");
        checkOutput("basic_wr_count", 32'(wr_count - wb), 32'd2);
        checkOutput("basic_w0_addr", 32'(wr_addr_log[wb]), 32'h0);
        checkOutput("basic_w0_data", wr_data_log[wb], 32'h0403_0201);
        checkOutput("basic_w0_be", 32'(wr_be_log[wb]), 32'hF);
        checkOutput("basic_w1_addr", 32'(wr_addr_log[wb+1]), 32'h1);
        checkOutput("basic_w1_data", wr_data_log[wb+1], 32'h0807_0605);
        checkOutput("basic_w1_be", 32'(wr_be_log[wb+1]), 32'hF);
        checkOutput("basic_rd_count", 32'(rd_count - rb), 32'd2);
        checkOutput("basic_checksum", checksum, 32'h0C0A_0806);
        checkOutput("basic_mismatch", 32'(mismatch), 32'h0);
        checkOutput("basic_error", 32'(error), 32'h0);
        @(negedge clk);
        checkOutput("basic_done_pulse", 32'(done), 32'h0);
        checkOutput("basic_busy_end", 32'(busy), 32'h0);

        $display("[TB] zero byte count");
        cb = cs_count;
        applyStimulus(13'h0005, 16'd0);
        waitDone("zero");
        checkOutput("zero_checksum", checksum, 32'h0);
        checkOutput("zero_error", 32'(error), 32'h0);
        @(negedge clk);
        checkOutput("zero_strobes", 32'(cs_count - cb), 32'd0);

        $display("[TB] partial final word");
        wb = wr_count; rb = rd_count;
        applyStimulus(13'h0010, 16'd5);
        stream_q = '{8'hAA, 8'hBB, 8'hCC, 8'hDD, 8'hEE};
        streamBytes(1'b0);
        waitDone("partial");
        checkOutput("partial_wr_count", 32'(wr_count - wb), 32'd2);
        checkOutput("partial_w0_addr", 32'(wr_addr_log[wb]), 32'h10);
        checkOutput("partial_w0_data", wr_data_log[wb], 32'hDDCC_BBAA);
        checkOutput("partial_w0_be", 32'(wr_be_log[wb]), 32'hF);
        checkOutput("partial_w1_addr", 32'(wr_addr_log[wb+1]), 32'h11);
        checkOutput("partial_w1_data", wr_data_log[wb+1], 32'h0000_00EE);
        checkOutput("partial_w1_be", 32'(wr_be_log[wb+1]), 32'h1);
        checkOutput("partial_rd_count", 32'(rd_count - rb), 32'd2);
        checkOutput("partial_checksum", checksum, 32'hDDCC_BC98);
        checkOutput("partial_mismatch", 32'(mismatch), 32'h0);
        @(negedge clk);

        $display("[TB] range error past the top of memory");
        cb = cs_count;
        applyStimulus(13'h1FFF, 16'd5);
        waitDone("range_err");
        checkOutput("range_err_error", 32'(error), 32'h1);
        checkOutput("range_err_checksum", checksum, 32'h0);
        checkOutput("range_err_mismatch", 32'(mismatch), 32'h0);
        @(negedge clk);
        checkOutput("range_err_strobes", 32'(cs_count - cb), 32'd0);
        checkOutput("range_err_sticky", 32'(error), 32'h1);

        $display("[TB] legal session ending exactly at the top of memory");
        wb = wr_count; rb = rd_count;
        applyStimulus(13'h1FFF, 16'd4);
        checkOutput("range_ok_error_clear", 32'(error), 32'h0);
        stream_q = '{8'h11, 8'h22, 8'h33, 8'h44};
        streamBytes(1'b0);
        waitDone("range_ok");
        checkOutput("range_ok_wr_count", 32'(wr_count - wb), 32'd1);
        checkOutput("range_ok_addr", 32'(wr_addr_log[wb]), 32'h1FFF);
        checkOutput("range_ok_data", wr_data_log[wb], 32'h4433_2211);
        checkOutput("range_ok_rd_count", 32'(rd_count - rb), 32'd1);
        checkOutput("range_ok_error", 32'(error), 32'h0);
        checkOutput("range_ok_checksum", checksum, 32'h4433_2211);
        checkOutput("range_ok_mismatch", 32'(mismatch), 32'h0);
        @(negedge clk);

        $display("[TB] readback corruption on word 1");
        flip_en   = 1'b1;
        flip_addr = 13'h0001;
        applyStimulus(13'h0000, 16'd8);
        stream_q = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h07, 8'h08};
        streamBytes(1'b0);
        waitDone("flip");
        checkOutput("flip_mismatch", 32'(mismatch), 32'h1);
        checkOutput("flip_checksum", checksum, 32'h0C0A_0806);
        checkOutput("flip_error", 32'(error), 32'h0);
        flip_en = 1'b0;
        @(negedge clk);
        checkOutput("flip_mismatch_sticky", 32'(mismatch), 32'h1);

        $display("[TB] basic load with stream gaps");
        wb = wr_count;
        applyStimulus(13'h0000, 16'd8);
        checkOutput("gaps_mismatch_clear", 32'(mismatch), 32'h0);
        streamBytes(1'b1);
        waitDone("gaps");
        checkOutput("gaps_wr_count", 32'(wr_count - wb), 32'd2);
        checkOutput("gaps_w0_addr", 32'(wr_addr_log[wb]), 32'h0);
        checkOutput("gaps_w0_data", wr_data_log[wb], 32'h0403_0201);
        checkOutput("gaps_w1_addr", 32'(wr_addr_log[wb+1]), 32'h1);
        checkOutput("gaps_w1_data", wr_data_log[wb+1], 32'h0807_0605);
        checkOutput("gaps_checksum", checksum, 32'h0C0A_0806);
        checkOutput("gaps_mismatch", 32'(mismatch), 32'h0);
        @(negedge clk);

        $display("[TB] reset in the middle of FILL");
        applyStimulus(13'h0020, 16'd8);
        stream_q = '{8'h5A, 8'hA5};
        streamBytes(1'b0);
        checkOutput("midrst_busy_before", 32'(busy), 32'h1);
        cb = cs_count;
        reset_n = 1'b0;
        @(negedge clk);
        checkOutput("midrst_busy", 32'(busy), 32'h0);
        checkOutput("midrst_s_ready", 32'(s_ready), 32'h0);
        checkOutput("midrst_clken", 32'(m_clken), 32'h0);
        @(negedge clk);
        reset_n = 1'b1;
        repeat (3) @(negedge clk);
        checkOutput("midrst_strobes", 32'(cs_count - cb), 32'd0);
        checkOutput("midrst_busy_after", 32'(busy), 32'h0);

        checkOutput("ready_violations", 32'(ready_viol), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
